ram_access_ctrl: RTL and testbench

//   Load/store front-end between the core's data-memory port and the word-wide ram peripheral.

---
 rtl/ram_access_ctrl_pkg.sv | 37 +++
 rtl/ram_access_ctrl_mem_lane_align.sv | 39 +++
 rtl/ram_access_ctrl.sv | 127 ++++++++++++
 tb/tb_ram_access_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_access_ctrl_pkg.sv
// rtl/ram_access_ctrl_pkg.sv - shared encodings, state codes and helpers for the RAM load/store front-end
package ram_access_ctrl_pkg;

    localparam int INST_DATA_BUS = 32;
    localparam logic [INST_DATA_BUS-1:0] ZERO_WORD = '0;

    localparam logic [1:0] MEM_SIZE_B   = 2'b00;
    localparam logic [1:0] MEM_SIZE_H   = 2'b01;
    localparam logic [1:0] MEM_SIZE_W   = 2'b10;
    localparam logic [1:0] MEM_SIZE_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    // Half needs addr[0]=0, word needs addr[1:0]=0; byte is always aligned.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
        case (size)
            MEM_SIZE_H: is_misaligned = addr_lo[0];
            MEM_SIZE_W: is_misaligned = |addr_lo;
            default:    is_misaligned = 1'b0;
        endcase
    endfunction

    // Clears the low address bits that the access size does not allow.
    function automatic logic [1:0] force_align(input logic [1:0] addr_lo, input logic [1:0] size);
        case (size)
            MEM_SIZE_H: force_align = {addr_lo[1], 1'b0};
            MEM_SIZE_W: force_align = 2'b00;
            default:    force_align = addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/ram_access_ctrl_mem_lane_align.sv
// rtl/ram_access_ctrl_mem_lane_align.sv - combinational lane extraction for loads and lane merge for stores
module mem_lane_align
    import ram_access_ctrl_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Pick the addressed lane, extend it for loads, and overwrite only that lane for stores.
    always_comb begin
        byte_v  = word_i[{addr_lo_i, 3'b000} +: 8];
        half_v  = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
        load_o  = word_i;
        store_o = word_i;
        case (size_i)
            MEM_SIZE_B: begin
                load_o = {{24{~unsigned_i & byte_v[7]}}, byte_v};
                store_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            MEM_SIZE_H: begin
                load_o = {{16{~unsigned_i & half_v[15]}}, half_v};
                store_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i;
            end
            default: begin
                load_o  = word_i;
                store_o = word_i;
            end
        endcase
    end

endmodule

// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - load/store front-end turning sized core accesses into word RAM accesses
module ram_access_ctrl
    import ram_access_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter bit MISALIGN_ERR = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [31:0]       wdata_i,
    output logic              ready_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic              ram_wr_en_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_data_o,
    input  logic [31:0]       ram_data_i
);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              uns_q;
    logic [15:0]       wdata_q;
    logic              ready_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic [31:0]       ram_data_q;

    logic              acc_err_d;
    logic [1:0]        addr_lo_d;
    logic [31:0]       load_val;
    logic [31:0]       merged_word;

    // Classify the incoming request and pick the latched low address bits.
    always_comb begin
        acc_err_d = (size_i == MEM_SIZE_RSV) ||
                    (MISALIGN_ERR && is_misaligned(addr_i[1:0], size_i));
        addr_lo_d = MISALIGN_ERR ? addr_i[1:0] : force_align(addr_i[1:0], size_i);
    end

    mem_lane_align u_lane_align (
        .word_i     (ram_data_i),
        .addr_lo_i  (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .load_o     (load_val),
        .store_o    (merged_word)
    );

    // Access FSM with registered handshake, load data and RAM write word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            size_q     <= MEM_SIZE_B;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            wdata_q    <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= ZERO_WORD;
            ram_data_q <= ZERO_WORD;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= ZERO_WORD;
            case (state_q)
                ST_IDLE: begin
                    if (req_i) begin
                        addr_q  <= {addr_i[ADDR_W-1:2], addr_lo_d};
                        size_q  <= size_i;
                        we_q    <= we_i;
                        uns_q   <= unsigned_i;
                        wdata_q <= wdata_i[15:0];
                        if (acc_err_d) begin
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= ST_RESP;
                        end else if (we_i && (size_i == MEM_SIZE_W)) begin
                            ram_data_q <= wdata_i;
                            state_q    <= ST_WRITE;
                        end else begin
                            state_q <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (we_q) begin
                        ram_data_q <= merged_word;
                        state_q    <= ST_WRITE;
                    end else begin
                        rdata_q <= load_val;
                        ready_q <= 1'b1;
                        state_q <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    ready_q <= 1'b1;
                    state_q <= ST_RESP;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // A reset landing on the WRITE cycle must not reach the RAM.
    always_comb begin
        ram_wr_en_o = (state_q == ST_WRITE) & rst_n;
    end

    assign ram_addr_o = {addr_q[ADDR_W-1:2], 2'b00};
    assign ram_data_o = ram_data_q;
    assign ready_o    = ready_q;
    assign err_o      = err_q;
    assign rdata_o    = rdata_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb/tb_ram_access_ctrl.sv - self-checking bench for ram_access_ctrl against a word-array reference model
module tb_ram_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        ram_wr_en_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_data_o;
    logic [31:0] ram_data_i;

    logic [31:0] ram_mem [0:63];
    logic [31:0] ref_mem [0:63];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_val;
    int          wr_count;
    logic [31:0] last_wr_addr;
    logic [31:0] last_wr_data;

    int vecs  = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ram_access_ctrl #(.ADDR_W(32), .MISALIGN_ERR(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .size_i      (size_i),
        .unsigned_i  (unsigned_i),
        .wdata_i     (wdata_i),
        .ready_o     (ready_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .ram_wr_en_o (ram_wr_en_o),
        .ram_addr_o  (ram_addr_o),
        .ram_data_o  (ram_data_o),
        .ram_data_i  (ram_data_i)
    );

    assign ram_data_i = ram_mem[ram_addr_o[7:2]];

    initial wr_count = 0;

    // RAM model: bench preload port plus DUT write port, and a write monitor.
    always @(posedge clk) begin
        if (pl_en) ram_mem[pl_idx] <= pl_val;
        if (ram_wr_en_o) begin
            ram_mem[ram_addr_o[7:2]] <= ram_data_o;
            wr_count     <= wr_count + 1;
            last_wr_addr <= ram_addr_o;
            last_wr_data <= ram_data_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        ref_mem[idx] = val;
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx[5:0]; pl_val = val;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic access(input logic w, input logic [31:0] a, input logic [1:0] sz,
                          input logic u, input logic [31:0] wd, input string tag);
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_rd;
        logic        exp_wr;
        logic [31:0] word, v, mask, newword;
        int          sh, lat, c0;
        word    = ref_mem[a[7:2]];
        exp_err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        sh      = (sz == 2'd0) ? 8 * a[1:0] : 16 * a[1];
        mask    = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        v       = (word >> sh) & mask;
        if (!u && sz == 2'd0 && v >= 32'h80)   v = v | 32'hFFFF_FF00;
        if (!u && sz == 2'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        newword = (word & ~(mask << sh)) | ((wd & mask) << sh);
        exp_rd  = (exp_err || w) ? 32'h0 : v;
        exp_wr  = w && !exp_err;
        exp_lat = exp_err ? 1 : (w && sz != 2'd2) ? 3 : 2;

        c0  = wr_count;
        lat = 0;
        @(negedge clk);
        req_i = 1'b1; we_i = w; addr_i = a; size_i = sz; unsigned_i = u; wdata_i = wd;
        @(posedge clk);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            req_i = 1'b0;
            if (ready_o) begin
                lat = n;
                break;
            end
        end
        check({tag, " latency"}, lat, exp_lat);
        if (lat != 0) begin
            check({tag, " err"}, {31'd0, err_o}, {31'd0, exp_err});
            check({tag, " rdata"}, rdata_o, exp_rd);
        end
        @(negedge clk);
        check({tag, " ready width"}, {31'd0, ready_o}, 32'd0);
        check({tag, " writes"}, wr_count - c0, exp_wr ? 32'd1 : 32'd0);
        if (exp_wr) begin
            check({tag, " wr addr"}, last_wr_addr, {a[31:2], 2'b00});
            check({tag, " wr data"}, last_wr_data, newword);
            ref_mem[a[7:2]] = newword;
        end
    endtask

    initial begin
        int c0, n;
        logic [1:0] rs;
        rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; size_i = '0;
        unsigned_i = 1'b0; wdata_i = '0; pl_en = 1'b0; pl_idx = '0; pl_val = '0;
        for (int i = 0; i < 64; i++) preload(i, $urandom);

        // Reset state
        check("rst ready", {31'd0, ready_o}, 32'd0);
        check("rst err", {31'd0, err_o}, 32'd0);
        check("rst rdata", rdata_o, 32'd0);
        check("rst wr_en", {31'd0, ram_wr_en_o}, 32'd0);
        check("rst addr", ram_addr_o, 32'd0);
        check("rst data", ram_data_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: byte loads with sign and zero extension
        preload(4, 32'h8899_AABB);
        access(1'b0, 32'h11, 2'd0, 1'b0, 32'h0, "t1 LB");
        check("t1 LB const", rdata_o, 32'h0);
        access(1'b0, 32'h11, 2'd0, 1'b1, 32'h0, "t1 LBU");
        // 2: byte store RMW
        access(1'b1, 32'h12, 2'd0, 1'b0, 32'h55, "t2 SB");
        check("t2 ram word4", ram_mem[4], 32'h8855_AABB);
        // 3: word store and reload
        access(1'b1, 32'h20, 2'd2, 1'b0, 32'hDEAD_BEEF, "t3 SW");
        access(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, "t3 LW");
        check("t3 ram word8", ram_mem[8], 32'hDEAD_BEEF);
        // 4: misaligned
        access(1'b0, 32'h03, 2'd1, 1'b0, 32'h0, "t4 LH mis");
        access(1'b1, 32'h06, 2'd2, 1'b0, 32'h1234_5678, "t4 SW mis");
        // 5: reserved size, then reset during the WRITE of a halfword store
        access(1'b0, 32'h08, 2'd3, 1'b0, 32'h0, "t5 RSV");
        c0 = wr_count;
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h2A; size_i = 2'd1; unsigned_i = 1'b0; wdata_i = 32'h0000_C0DE;
        @(posedge clk);
        @(negedge clk);
        req_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5 wr_en in reset", {31'd0, ram_wr_en_o}, 32'd0);
        @(negedge clk);
        check("t5 no write", wr_count - c0, 32'd0);
        check("t5 ready", {31'd0, ready_o}, 32'd0);
        check("t5 err", {31'd0, err_o}, 32'd0);
        check("t5 rdata", rdata_o, 32'd0);
        check("t5 addr", ram_addr_o, 32'd0);
        check("t5 data", ram_data_o, 32'd0);
        check("t5 mem", ram_mem[10], ref_mem[10]);
        rst_n = 1'b1;

        // 6: back-to-back SW then LW with req held throughout
        c0 = wr_count;
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h24; size_i = 2'd2; unsigned_i = 1'b0; wdata_i = 32'hCAFE_F00D;
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (ready_o) begin n = i; break; end
        end
        check("t6 first latency", n, 32'd2);
        ref_mem[9] = 32'hCAFE_F00D;
        we_i = 1'b0; wdata_i = 32'h0;
        @(negedge clk);
        check("t6 gap1", {31'd0, ready_o}, 32'd0);
        @(negedge clk);
        check("t6 gap2", {31'd0, ready_o}, 32'd0);
        @(negedge clk);
        req_i = 1'b0;
        check("t6 second ready", {31'd0, ready_o}, 32'd1);
        check("t6 LW data", rdata_o, 32'hCAFE_F00D);
        @(negedge clk);
        check("t6 second width", {31'd0, ready_o}, 32'd0);
        check("t6 writes", wr_count - c0, 32'd1);

        // Randomized accesses against the reference model
        for (int i = 0; i < 60; i++) begin
            rs = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
            access(1'($urandom), 32'($urandom_range(0, 255)), rs, 1'($urandom), $urandom, "rand");
        end
        for (int i = 0; i < 64; i++) check("final mem", ram_mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
